dispatch_stage: RTL and testbench

//  Registered, parametrised rename/dispatch stage between decoder and issue queues (RS / LS-queue).

---
 rtl/dispatch_stage.sv | 218 +++++++++++++++++++++
 tb/tb_dispatch_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dispatch_stage                                             |
// | Description : Registered rename/dispatch stage: resolves source operands |
// |               from regfile, ROB and CDB, allocates a ROB tag and holds   |
// |               one entry for RS / LS-queue with CDB wake-up while held.   |
// |               Optional DISPATCH_PERF_EN adds dispatch/stall counters.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module dispatch_stage #(
  parameter int XLEN    = 32,
  parameter int ROB_W   = 4,
  parameter int TYPE_W  = 6,
  parameter int NUM_CDB = 2,
  parameter logic [TYPE_W-1:0] LS_LO = TYPE_W'(10),
  parameter logic [TYPE_W-1:0] LS_HI = TYPE_W'(17)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     dec_valid_in,
  output logic                     dec_ready_out,
  input  logic [TYPE_W-1:0]        dec_type_in,
  input  logic [4:0]               dec_rs1_in,
  input  logic [4:0]               dec_rs2_in,
  input  logic [4:0]               dec_rd_in,
  input  logic [XLEN-1:0]          dec_imm_in,
  input  logic [XLEN-1:0]          dec_pc_in,
  output logic [4:0]               reg_rs1_out,
  output logic [4:0]               reg_rs2_out,
  input  logic [XLEN-1:0]          reg_rs1_data_in,
  input  logic                     reg_rs1_busy_in,
  input  logic [ROB_W-1:0]         reg_rs1_tag_in,
  input  logic [XLEN-1:0]          reg_rs2_data_in,
  input  logic                     reg_rs2_busy_in,
  input  logic [ROB_W-1:0]         reg_rs2_tag_in,
  input  logic                     rob_alloc_ready_in,
  input  logic [ROB_W-1:0]         rob_alloc_tag_in,
  output logic                     rob_alloc_valid_out,
  output logic [ROB_W-1:0]         rob_rs1_tag_out,
  output logic [ROB_W-1:0]         rob_rs2_tag_out,
  input  logic                     rob_rs1_rdy_in,
  input  logic [XLEN-1:0]          rob_rs1_data_in,
  input  logic                     rob_rs2_rdy_in,
  input  logic [XLEN-1:0]          rob_rs2_data_in,
  output logic                     rename_we_out,
  output logic [4:0]               rename_rd_out,
  output logic [ROB_W-1:0]         rename_tag_out,
  input  logic [NUM_CDB-1:0]       cdb_valid_in,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_tag_in,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_data_in,
  output logic                     iss_valid_out,
  output logic                     iss_to_lsq_out,
  input  logic                     rs_ready_in,
  input  logic                     lsq_ready_in,
  output logic [XLEN-1:0]          iss_vj_out,
  output logic [XLEN-1:0]          iss_vk_out,
  output logic [ROB_W-1:0]         iss_qj_out,
  output logic [ROB_W-1:0]         iss_qk_out,
  output logic                     iss_qj_busy_out,
  output logic                     iss_qk_busy_out,
  output logic [TYPE_W-1:0]        iss_type_out,
  output logic [XLEN-1:0]          iss_imm_out,
  output logic [XLEN-1:0]          iss_pc_out,
  output logic [ROB_W-1:0]         iss_dest_out
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]              perf_disp_out,
  output logic [31:0]              perf_stall_out
`endif
);

  localparam int c_OP_W = XLEN + ROB_W + 1;

  logic                r_valid, r_to_lsq, r_qj_busy, r_qk_busy;
  logic [TYPE_W-1:0]   r_type;
  logic [XLEN-1:0]     r_imm, r_pc, r_vj, r_vk;
  logic [ROB_W-1:0]    r_dest, r_qj, r_qk;

  logic                w_drain, w_accept, w_is_ls;
  logic [XLEN-1:0]     w_cdb_data [NUM_CDB];
  logic [ROB_W-1:0]    w_cdb_tag  [NUM_CDB];
  logic [c_OP_W-1:0]   w_op1, w_op2;
  logic [XLEN:0]       w_wk_j, w_wk_k;

  for (genvar i = 0; i < NUM_CDB; i++) begin : g_cdb
    assign w_cdb_tag[i]  = cdb_tag_in[i*ROB_W +: ROB_W];
    assign w_cdb_data[i] = cdb_data_in[i*XLEN +: XLEN];
  end

  // Returns {hit, data}; walking down from the top lets the lowest channel win.
  function automatic logic [XLEN:0] cdb_lookup(input logic [ROB_W-1:0] tag);
    logic [XLEN:0] res;
    res = '0;
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (cdb_valid_in[i] && (w_cdb_tag[i] == tag)) res = {1'b1, w_cdb_data[i]};
    end
    return res;
  endfunction

  // Returns {pending, tag, value}.
  function automatic logic [c_OP_W-1:0] resolve(
    input logic [4:0]       rs,
    input logic             busy,
    input logic [ROB_W-1:0] tag,
    input logic [XLEN-1:0]  rf_data,
    input logic             rob_rdy,
    input logic [XLEN-1:0]  rob_data
  );
    logic [XLEN:0] hit;
    hit = cdb_lookup(tag);
    if (rs == 5'd0)       return '0;
    else if (!busy)       return {1'b0, {ROB_W{1'b0}}, rf_data};
    else if (rob_rdy)     return {1'b0, {ROB_W{1'b0}}, rob_data};
    else if (hit[XLEN])   return {1'b0, {ROB_W{1'b0}}, hit[XLEN-1:0]};
    else                  return {1'b1, tag, {XLEN{1'b0}}};
  endfunction

  assign w_drain    = r_valid & (r_to_lsq ? lsq_ready_in : rs_ready_in);
  assign dec_ready_out = rdy_in & ~flush_in & rob_alloc_ready_in & (~r_valid | w_drain);
  assign w_accept   = dec_valid_in & dec_ready_out;
  assign w_is_ls    = (dec_type_in >= LS_LO) && (dec_type_in <= LS_HI);

  assign rob_alloc_valid_out = w_accept;
  assign rename_we_out       = w_accept & (dec_rd_in != 5'd0);
  assign rename_rd_out       = dec_rd_in;
  assign rename_tag_out      = rob_alloc_tag_in;
  assign reg_rs1_out         = dec_rs1_in;
  assign reg_rs2_out         = dec_rs2_in;
  assign rob_rs1_tag_out     = reg_rs1_tag_in;
  assign rob_rs2_tag_out     = reg_rs2_tag_in;

  assign w_op1  = resolve(dec_rs1_in, reg_rs1_busy_in, reg_rs1_tag_in, reg_rs1_data_in,
                          rob_rs1_rdy_in, rob_rs1_data_in);
  assign w_op2  = resolve(dec_rs2_in, reg_rs2_busy_in, reg_rs2_tag_in, reg_rs2_data_in,
                          rob_rs2_rdy_in, rob_rs2_data_in);
  assign w_wk_j = cdb_lookup(r_qj);
  assign w_wk_k = cdb_lookup(r_qk);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid   <= 1'b0;
      r_to_lsq  <= 1'b0;
      r_type    <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_dest    <= '0;
      r_vj      <= '0;
      r_vk      <= '0;
      r_qj      <= '0;
      r_qk      <= '0;
      r_qj_busy <= 1'b0;
      r_qk_busy <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid   <= 1'b1;
        r_to_lsq  <= w_is_ls;
        r_type    <= dec_type_in;
        r_imm     <= dec_imm_in;
        r_pc      <= dec_pc_in;
        r_dest    <= rob_alloc_tag_in;
        r_vj      <= w_op1[XLEN-1:0];
        r_qj      <= w_op1[XLEN +: ROB_W];
        r_qj_busy <= w_op1[c_OP_W-1];
        r_vk      <= w_op2[XLEN-1:0];
        r_qk      <= w_op2[XLEN +: ROB_W];
        r_qk_busy <= w_op2[c_OP_W-1];
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end else if (r_valid) begin
        // A draining entry skips wake-up: the receiving queue snoops that CDB itself.
        if (r_qj_busy && w_wk_j[XLEN]) begin
          r_vj      <= w_wk_j[XLEN-1:0];
          r_qj_busy <= 1'b0;
        end
        if (r_qk_busy && w_wk_k[XLEN]) begin
          r_vk      <= w_wk_k[XLEN-1:0];
          r_qk_busy <= 1'b0;
        end
      end
    end
  end

  assign iss_valid_out   = r_valid;
  assign iss_to_lsq_out  = r_to_lsq;
  assign iss_type_out    = r_type;
  assign iss_imm_out     = r_imm;
  assign iss_pc_out      = r_pc;
  assign iss_dest_out    = r_dest;
  assign iss_vj_out      = r_vj;
  assign iss_vk_out      = r_vk;
  assign iss_qj_out      = r_qj;
  assign iss_qk_out      = r_qk;
  assign iss_qj_busy_out = r_qj_busy;
  assign iss_qk_busy_out = r_qk_busy;

`ifdef DISPATCH_PERF_EN
  logic [31:0] r_perf_disp, r_perf_stall;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_perf_disp  <= '0;
      r_perf_stall <= '0;
    end else if (rdy_in) begin
      if (w_accept)                        r_perf_disp  <= r_perf_disp + 32'd1;
      if (dec_valid_in && !dec_ready_out)  r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_disp_out  = r_perf_disp;
  assign perf_stall_out = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dispatch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dispatch_stage                                          |
// | Description : Scoreboard bench for dispatch_stage with random stimulus.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_dispatch_stage;

  localparam logic [5:0] c_LS_LO = 6'd10;
  localparam logic [5:0] c_LS_HI = 6'd17;

  logic        clk_in = 1'b0, rst_in, rdy_in, flush_in, dec_valid_in, dec_ready_out;
  logic [5:0]  dec_type_in;
  logic [4:0]  dec_rs1_in, dec_rs2_in, dec_rd_in, reg_rs1_out, reg_rs2_out, rename_rd_out;
  logic [31:0] dec_imm_in, dec_pc_in, reg_rs1_data_in, reg_rs2_data_in;
  logic        reg_rs1_busy_in, reg_rs2_busy_in, rob_alloc_ready_in, rob_alloc_valid_out;
  logic [3:0]  reg_rs1_tag_in, reg_rs2_tag_in, rob_alloc_tag_in, rob_rs1_tag_out, rob_rs2_tag_out;
  logic        rob_rs1_rdy_in, rob_rs2_rdy_in, rename_we_out;
  logic [31:0] rob_rs1_data_in, rob_rs2_data_in;
  logic [3:0]  rename_tag_out;
  logic [1:0]  cdb_valid_in;
  logic [3:0]  cdb_tag_a [2];
  logic [31:0] cdb_data_a [2];
  logic [7:0]  cdb_tag_in;
  logic [63:0] cdb_data_in;
  logic        iss_valid_out, iss_to_lsq_out, rs_ready_in, lsq_ready_in;
  logic [31:0] iss_vj_out, iss_vk_out, iss_imm_out, iss_pc_out;
  logic [3:0]  iss_qj_out, iss_qk_out, iss_dest_out;
  logic        iss_qj_busy_out, iss_qk_busy_out;
  logic [5:0]  iss_type_out;
`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_disp_out, perf_stall_out;
  int unsigned exp_disp = 0, exp_stall = 0;
`endif

  assign cdb_tag_in  = {cdb_tag_a[1], cdb_tag_a[0]};
  assign cdb_data_in = {cdb_data_a[1], cdb_data_a[0]};

  dispatch_stage #(.XLEN(32), .ROB_W(4), .TYPE_W(6), .NUM_CDB(2),
                   .LS_LO(c_LS_LO), .LS_HI(c_LS_HI)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out),
    .dec_type_in(dec_type_in), .dec_rs1_in(dec_rs1_in), .dec_rs2_in(dec_rs2_in),
    .dec_rd_in(dec_rd_in), .dec_imm_in(dec_imm_in), .dec_pc_in(dec_pc_in),
    .reg_rs1_out(reg_rs1_out), .reg_rs2_out(reg_rs2_out),
    .reg_rs1_data_in(reg_rs1_data_in), .reg_rs1_busy_in(reg_rs1_busy_in),
    .reg_rs1_tag_in(reg_rs1_tag_in), .reg_rs2_data_in(reg_rs2_data_in),
    .reg_rs2_busy_in(reg_rs2_busy_in), .reg_rs2_tag_in(reg_rs2_tag_in),
    .rob_alloc_ready_in(rob_alloc_ready_in), .rob_alloc_tag_in(rob_alloc_tag_in),
    .rob_alloc_valid_out(rob_alloc_valid_out),
    .rob_rs1_tag_out(rob_rs1_tag_out), .rob_rs2_tag_out(rob_rs2_tag_out),
    .rob_rs1_rdy_in(rob_rs1_rdy_in), .rob_rs1_data_in(rob_rs1_data_in),
    .rob_rs2_rdy_in(rob_rs2_rdy_in), .rob_rs2_data_in(rob_rs2_data_in),
    .rename_we_out(rename_we_out), .rename_rd_out(rename_rd_out),
    .rename_tag_out(rename_tag_out),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
    .iss_valid_out(iss_valid_out), .iss_to_lsq_out(iss_to_lsq_out),
    .rs_ready_in(rs_ready_in), .lsq_ready_in(lsq_ready_in),
    .iss_vj_out(iss_vj_out), .iss_vk_out(iss_vk_out),
    .iss_qj_out(iss_qj_out), .iss_qk_out(iss_qk_out),
    .iss_qj_busy_out(iss_qj_busy_out), .iss_qk_busy_out(iss_qk_busy_out),
    .iss_type_out(iss_type_out), .iss_imm_out(iss_imm_out), .iss_pc_out(iss_pc_out),
    .iss_dest_out(iss_dest_out)
`ifdef DISPATCH_PERF_EN
    , .perf_disp_out(perf_disp_out), .perf_stall_out(perf_stall_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [5:0]  typ;
    logic [31:0] imm, pc, vj, vk;
    logic [3:0]  dest, qj, qk;
    logic        to_lsq, bj, bk;
    int          born;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0, n_fail = 0, cyc = 0;
  bit   started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Lowest-numbered valid channel carrying the tag supplies the value.
  task automatic cdb_match(input logic [3:0] tag, output logic hit, output logic [31:0] d);
    hit = 1'b0; d = '0;
    for (int i = 0; i < 2; i++)
      if (!hit && cdb_valid_in[i] && cdb_tag_a[i] == tag) begin hit = 1'b1; d = cdb_data_a[i]; end
  endtask

  task automatic resolve(input logic [4:0] rs, input logic busy, input logic [3:0] tag,
                         input logic [31:0] rf, input logic rr, input logic [31:0] rob_d,
                         output logic [31:0] v, output logic [3:0] qt, output logic p);
    logic hit; logic [31:0] cd;
    v = '0; qt = '0; p = 1'b0;
    if (rs != 5'd0) begin
      if (!busy) v = rf;
      else if (rr) v = rob_d;
      else begin
        cdb_match(tag, hit, cd);
        if (hit) v = cd;
        else begin p = 1'b1; qt = tag; end
      end
    end
  endtask

  task automatic quiet();
    rdy_in = 1'b1; flush_in = 1'b0; dec_valid_in = 1'b0; rob_alloc_ready_in = 1'b1;
    rs_ready_in = 1'b1; lsq_ready_in = 1'b1; dec_type_in = 6'd0;
    dec_rs1_in = 5'd0; dec_rs2_in = 5'd0; dec_rd_in = 5'd0;
    dec_imm_in = '0; dec_pc_in = '0; rob_alloc_tag_in = 4'd0;
    reg_rs1_data_in = '0; reg_rs1_busy_in = 1'b0; reg_rs1_tag_in = '0;
    reg_rs2_data_in = '0; reg_rs2_busy_in = 1'b0; reg_rs2_tag_in = '0;
    rob_rs1_rdy_in = 1'b0; rob_rs1_data_in = '0; rob_rs2_rdy_in = 1'b0; rob_rs2_data_in = '0;
    cdb_valid_in = 2'b00;
    for (int i = 0; i < 2; i++) begin cdb_tag_a[i] = '0; cdb_data_a[i] = '0; end
  endtask

  task automatic rand_inputs();
    rdy_in = ($urandom_range(0, 7) != 0);
    flush_in = ($urandom_range(0, 15) == 0);
    dec_valid_in = ($urandom_range(0, 3) != 0);
    rob_alloc_ready_in = ($urandom_range(0, 7) != 0);
    rs_ready_in = ($urandom_range(0, 2) != 0);
    lsq_ready_in = ($urandom_range(0, 2) != 0);
    dec_type_in = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(8, 19)) : 6'($urandom_range(0, 63));
    dec_rs1_in = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    dec_rs2_in = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    dec_rd_in  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    dec_imm_in = $urandom; dec_pc_in = $urandom;
    rob_alloc_tag_in = 4'($urandom_range(0, 15));
    reg_rs1_data_in = $urandom; reg_rs1_busy_in = 1'($urandom_range(0, 1));
    reg_rs1_tag_in = 4'($urandom_range(0, 3));
    reg_rs2_data_in = $urandom; reg_rs2_busy_in = 1'($urandom_range(0, 1));
    reg_rs2_tag_in = 4'($urandom_range(0, 3));
    rob_rs1_rdy_in = ($urandom_range(0, 3) == 0); rob_rs1_data_in = $urandom;
    rob_rs2_rdy_in = ($urandom_range(0, 3) == 0); rob_rs2_data_in = $urandom;
    cdb_valid_in = 2'($urandom_range(0, 3));
    for (int i = 0; i < 2; i++) begin
      cdb_tag_a[i] = 4'($urandom_range(0, 3)); cdb_data_a[i] = $urandom;
    end
  endtask

  // Called right after inputs are set at a falling edge; predicts the handshake.
  task automatic step();
    exp_t e;
    logic held, drain_m, exp_rdy, exp_acc;
    cyc++;
    #1;
    held    = (q.size() > 0) && (q[0].born < cyc);
    drain_m = held && (q[0].to_lsq ? lsq_ready_in : rs_ready_in);
    exp_rdy = rdy_in && !flush_in && rob_alloc_ready_in && (!held || drain_m);
    exp_acc = dec_valid_in && exp_rdy;
    chk("dec_ready", dec_ready_out, exp_rdy);
    chk("rob_alloc_valid", rob_alloc_valid_out, exp_acc);
    chk("rename_we", rename_we_out, exp_acc && (dec_rd_in != 5'd0));
    chk("rename_tag", rename_tag_out, rob_alloc_tag_in);
    chk("reg_rs1_idx", reg_rs1_out, dec_rs1_in);
    chk("rob_rs2_tag", rob_rs2_tag_out, reg_rs2_tag_in);
`ifdef DISPATCH_PERF_EN
    if (exp_acc) exp_disp++;
    if (rdy_in && dec_valid_in && !exp_rdy) exp_stall++;
`endif
    if (exp_acc) begin
      e.typ = dec_type_in; e.imm = dec_imm_in; e.pc = dec_pc_in; e.dest = rob_alloc_tag_in;
      e.to_lsq = (dec_type_in >= c_LS_LO) && (dec_type_in <= c_LS_HI);
      resolve(dec_rs1_in, reg_rs1_busy_in, reg_rs1_tag_in, reg_rs1_data_in,
              rob_rs1_rdy_in, rob_rs1_data_in, e.vj, e.qj, e.bj);
      resolve(dec_rs2_in, reg_rs2_busy_in, reg_rs2_tag_in, reg_rs2_data_in,
              rob_rs2_rdy_in, rob_rs2_data_in, e.vk, e.qk, e.bk);
      e.born = cyc;
      q.push_back(e);
    end
  endtask

  // Monitor: compares the held entry each cycle, retires it on drain/flush, applies wake-ups.
  initial begin
    exp_t me;
    logic m_held, hit;
    logic [31:0] cd;
    forever begin
      @(negedge clk_in);
      #2;
      if (started && !rst_in) begin
        m_held = (q.size() > 0) && (q[0].born < cyc);
        chk("iss_valid", iss_valid_out, m_held);
        if (m_held && iss_valid_out) begin
          me = q[0];
          chk("iss_type", iss_type_out, me.typ);
          chk("iss_imm", iss_imm_out, me.imm);
          chk("iss_pc", iss_pc_out, me.pc);
          chk("iss_dest", iss_dest_out, me.dest);
          chk("iss_to_lsq", iss_to_lsq_out, me.to_lsq);
          chk("qj_busy", iss_qj_busy_out, me.bj);
          chk("qk_busy", iss_qk_busy_out, me.bk);
          if (me.bj) chk("qj", iss_qj_out, me.qj); else chk("vj", iss_vj_out, me.vj);
          if (me.bk) chk("qk", iss_qk_out, me.qk); else chk("vk", iss_vk_out, me.vk);
        end
        if (m_held && rdy_in) begin
          me = q[0];
          if (flush_in || (me.to_lsq ? lsq_ready_in : rs_ready_in)) void'(q.pop_front());
          else begin
            if (me.bj) begin cdb_match(me.qj, hit, cd); if (hit) begin me.vj = cd; me.bj = 1'b0; end end
            if (me.bk) begin cdb_match(me.qk, hit, cd); if (hit) begin me.vk = cd; me.bk = 1'b0; end end
            q[0] = me;
          end
        end
      end
    end
  end

  initial begin
    quiet();
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    #1;
    chk("rst_valid", iss_valid_out, 1'b0);
    chk("rst_vj", iss_vj_out, 32'd0);
    chk("rst_qk_busy", iss_qk_busy_out, 1'b0);
    chk("rst_dest", iss_dest_out, 4'd0);
    @(negedge clk_in); rst_in = 1'b0; started = 1'b1; step();

    // ADD x3,x1,x2 with ready operands
    @(negedge clk_in); quiet(); dec_valid_in = 1'b1; dec_rs1_in = 5'd1; dec_rs2_in = 5'd2;
    dec_rd_in = 5'd3; reg_rs1_data_in = 32'd5; reg_rs2_data_in = 32'd7; rob_alloc_tag_in = 4'd6;
    step();
    // back-to-back: x1 busy on tag 4, not in ROB
    @(negedge clk_in); quiet(); dec_valid_in = 1'b1; dec_type_in = 6'd1; dec_rs1_in = 5'd1;
    reg_rs1_busy_in = 1'b1; reg_rs1_tag_in = 4'd4; dec_rs2_in = 5'd2; reg_rs2_data_in = 32'd3;
    dec_rd_in = 5'd5; rob_alloc_tag_in = 4'd7; step();
    repeat (3) begin @(negedge clk_in); quiet(); rs_ready_in = 1'b0; step(); end
    @(negedge clk_in); quiet(); rs_ready_in = 1'b0; cdb_valid_in = 2'b10;
    cdb_tag_a[1] = 4'd4; cdb_data_a[1] = 32'h99; step();
    @(negedge clk_in); quiet(); step();
    // LW blocked by LS-queue, second instruction waits, then drain+accept
    @(negedge clk_in); quiet(); dec_valid_in = 1'b1; dec_type_in = c_LS_LO + 6'd2;
    lsq_ready_in = 1'b0; rob_alloc_tag_in = 4'd8; step();
    repeat (2) begin
      @(negedge clk_in); quiet(); dec_valid_in = 1'b1; lsq_ready_in = 1'b0;
      dec_rd_in = 5'd9; rob_alloc_tag_in = 4'd9; step();
    end
    @(negedge clk_in); quiet(); dec_valid_in = 1'b1; dec_rd_in = 5'd9; rob_alloc_tag_in = 4'd9; step();
    @(negedge clk_in); quiet(); step();
    // ROB full, then flush of a held entry
    @(negedge clk_in); quiet(); dec_valid_in = 1'b1; rob_alloc_ready_in = 1'b0; dec_rd_in = 5'd4; step();
    @(negedge clk_in); quiet(); dec_valid_in = 1'b1; rs_ready_in = 1'b0; dec_rd_in = 5'd4; step();
    @(negedge clk_in); quiet(); dec_valid_in = 1'b1; rs_ready_in = 1'b0; flush_in = 1'b1; step();
    @(negedge clk_in); quiet(); step();
    // x0 source ignores busy
    @(negedge clk_in); quiet(); dec_valid_in = 1'b1; reg_rs1_busy_in = 1'b1; reg_rs1_tag_in = 4'd2;
    reg_rs1_data_in = 32'hdead; step();
    @(negedge clk_in); quiet(); step();

    repeat (3000) begin @(negedge clk_in); rand_inputs(); step(); end

    // asynchronous reset while an entry is held
    @(negedge clk_in); quiet(); dec_valid_in = 1'b1; rs_ready_in = 1'b0; step();
    @(negedge clk_in); quiet(); rs_ready_in = 1'b0; step();
    #3 rst_in = 1'b1;
    #1 chk("async_rst_valid", iss_valid_out, 1'b0);
    q.delete();
`ifdef DISPATCH_PERF_EN
    exp_disp = 0; exp_stall = 0;
`endif
    @(negedge clk_in); quiet(); rst_in = 1'b0; step();
    @(negedge clk_in); quiet(); step();
`ifdef DISPATCH_PERF_EN
    chk("perf_disp", perf_disp_out, exp_disp);
    chk("perf_stall", perf_stall_out, exp_stall);
`endif
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
